// File: rtl/demux_sched_1x8_if.sv
// Bundles the stream handshake, the per-channel outputs, sel and busy of the 1x8 demux scheduler.
// The master modport is the environment (upstream and consumers). The slave modport is the scheduler.
interface demux_sched_1x8_if #(
    parameter int DW = 8
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [7:0]    out_valid;
    logic [7:0]    out_ready;
    logic [2:0]    sel;
    logic          busy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel, busy
    );
endinterface

// File: rtl/demux_sched_1x8.sv
// Round-robin scheduler for the 1x8 demux tree. It grants one channel at a time for up to BURST words,
// and presents a registered word with a one-hot valid on the granted channel.
module demux_sched_1x8 #(
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input logic               clk,
    input logic               rst,
    demux_sched_1x8_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARB  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;

    localparam logic [3:0] BURST_C = 4'(BURST);

    logic [1:0]    state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    sel_q, sel_d;
    logic [3:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]    del_cnt_q, del_cnt_d;
    logic          ov_q, ov_d;
    logic [DW-1:0] data_q, data_d;

    logic          in_ready_c;
    logic          load_c;
    logic          deliver_c;
    logic          rel_c;
    logic          hit_c;
    logic [2:0]    hit_idx_c;

    // First ready channel at or after ptr, wrapping modulo 8.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = ptr_q;
        for (int i = 0; i < 8; i++) begin
            if (!hit_c && bus.out_ready[ptr_q + 3'(i)]) begin
                hit_c     = 1'b1;
                hit_idx_c = ptr_q + 3'(i);
            end
        end
    end

    // in_ready has no path from in_valid. It depends only on the registered state and on the granted consumer.
    always_comb begin
        in_ready_c = (state_q == S_XFER) && (acc_cnt_q < BURST_C) &&
                     (!ov_q || bus.out_ready[sel_q]);
        load_c     = bus.in_valid && in_ready_c;
        deliver_c  = (state_q == S_XFER) && ov_q && bus.out_ready[sel_q];
        rel_c      = (state_q == S_XFER) &&
                     (((del_cnt_q + {3'b000, deliver_c}) == BURST_C) ||
                      (!ov_q && !bus.in_valid));
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        acc_cnt_d = acc_cnt_q;
        del_cnt_d = del_cnt_q;
        ov_d      = ov_q;
        data_d    = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) state_d = S_ARB;
            end
            S_ARB: begin
                if (!bus.in_valid) begin
                    state_d = S_IDLE;
                end else if (hit_c) begin
                    sel_d     = hit_idx_c;
                    acc_cnt_d = 4'd0;
                    del_cnt_d = 4'd0;
                    state_d   = S_XFER;
                end
            end
            S_XFER: begin
                // A load in the delivery cycle replaces the word, so ov stays set at full throughput.
                if (load_c) begin
                    data_d    = bus.in_data;
                    ov_d      = 1'b1;
                    acc_cnt_d = acc_cnt_q + 4'd1;
                end else if (deliver_c) begin
                    ov_d = 1'b0;
                end
                if (deliver_c) del_cnt_d = del_cnt_q + 4'd1;
                if (rel_c) begin
                    ptr_d   = sel_q + 3'd1;
                    state_d = bus.in_valid ? S_ARB : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 3'd0;
            sel_q     <= 3'd0;
            acc_cnt_q <= 4'd0;
            del_cnt_q <= 4'd0;
            ov_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            acc_cnt_q <= acc_cnt_d;
            del_cnt_q <= del_cnt_d;
            ov_q      <= ov_d;
            data_q    <= data_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = data_q;
    assign bus.out_valid = ov_q ? (8'b0000_0001 << sel_q) : 8'b0000_0000;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == S_ARB) || (state_q == S_XFER);
endmodule
